// File: rtl/pipe_stall_ctrl.sv
// Hazard and stall controller for a five-stage pipeline: drives the register
// enables, bubble and flush controls, and tracks stall cycles and memory timeouts.
module pipe_stall_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  id_rs1,
    input  logic [2:0]  id_rs2,
    input  logic        id_rs1_used,
    input  logic        id_rs2_used,
    input  logic [2:0]  ex_rd,
    input  logic        ex_rd_write,
    input  logic        ex_mem_read,
    input  logic        ex_branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    input  logic        halt_req,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        idex_bubble,
    output logic        ifid_flush,
    output logic        stall_active,
    output logic [15:0] stall_cnt,
    output logic        mem_timeout
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALTED   = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(MEM_TIMEOUT);

    state_t      state_r;
    state_t      state_next_s;
    logic [7:0]  wait_cnt_r;
    logic [7:0]  wait_cnt_next_s;
    logic [15:0] stall_cnt_r;
    logic        mem_timeout_r;

    logic        halt_s;
    logic        mem_wait_s;
    logic        load_use_s;
    logic        timeout_hit_s;
    logic        pc_en_s;
    logic        ifid_en_s;
    logic        idex_en_s;
    logic        exmem_en_s;
    logic        memwb_en_s;
    logic        idex_bubble_s;
    logic        ifid_flush_s;
    logic        stall_active_s;

    // Hazard condition decode; register 0 is deliberately not exempt from matching
    always_comb begin
        halt_s     = (state_r == HALTED) || halt_req;
        mem_wait_s = mem_req && !mem_ready;
        load_use_s = ex_mem_read && ex_rd_write &&
                     ((id_rs1_used && (id_rs1 == ex_rd)) ||
                      (id_rs2_used && (id_rs2 == ex_rd)));
    end

    // Prioritised control decode: halt > memory wait > branch > load-use > run
    always_comb begin
        pc_en_s         = 1'b0;
        ifid_en_s       = 1'b0;
        idex_en_s       = 1'b0;
        exmem_en_s      = 1'b0;
        memwb_en_s      = 1'b0;
        idex_bubble_s   = 1'b0;
        ifid_flush_s    = 1'b0;
        state_next_s    = state_r;
        wait_cnt_next_s = wait_cnt_r;
        if (!rst) begin
            state_next_s    = RUN;
            wait_cnt_next_s = 8'd0;
        end else if (halt_s) begin
            state_next_s    = HALTED;
            wait_cnt_next_s = 8'd0;
        end else if (mem_wait_s) begin
            state_next_s = MEM_WAIT;
            if (wait_cnt_r != 8'hFF) begin
                wait_cnt_next_s = wait_cnt_r + 8'd1;
            end else begin
                wait_cnt_next_s = wait_cnt_r;
            end
        end else begin
            // Memory released or idle: rules below also act on whatever EX held frozen
            state_next_s    = RUN;
            wait_cnt_next_s = 8'd0;
            if (ex_branch_taken) begin
                pc_en_s       = 1'b1;
                ifid_en_s     = 1'b1;
                idex_en_s     = 1'b1;
                exmem_en_s    = 1'b1;
                memwb_en_s    = 1'b1;
                idex_bubble_s = 1'b1;
                ifid_flush_s  = 1'b1;
            end else if (load_use_s) begin
                pc_en_s       = 1'b0;
                ifid_en_s     = 1'b0;
                idex_en_s     = 1'b1;
                exmem_en_s    = 1'b1;
                memwb_en_s    = 1'b1;
                idex_bubble_s = 1'b1;
            end else begin
                pc_en_s    = 1'b1;
                ifid_en_s  = 1'b1;
                idex_en_s  = 1'b1;
                exmem_en_s = 1'b1;
                memwb_en_s = 1'b1;
            end
        end
    end

    // Stall indication and the timeout trigger for the wait cycle now ending
    always_comb begin
        stall_active_s = rst && !pc_en_s && (state_r != HALTED);
        timeout_hit_s  = rst && !halt_s && mem_wait_s &&
                         (wait_cnt_next_s >= TIMEOUT_LIMIT);
    end

    // State, wait counter, saturating stall counter and sticky timeout flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= RUN;
            wait_cnt_r    <= 8'd0;
            stall_cnt_r   <= 16'd0;
            mem_timeout_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            wait_cnt_r <= wait_cnt_next_s;
            if (stall_active_s && (stall_cnt_r != 16'hFFFF)) begin
                stall_cnt_r <= stall_cnt_r + 16'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (timeout_hit_s) begin
                mem_timeout_r <= 1'b1;
            end else begin
                mem_timeout_r <= mem_timeout_r;
            end
        end
    end

    assign pc_en        = pc_en_s;
    assign ifid_en      = ifid_en_s;
    assign idex_en      = idex_en_s;
    assign exmem_en     = exmem_en_s;
    assign memwb_en     = memwb_en_s;
    assign idex_bubble  = idex_bubble_s;
    assign ifid_flush   = ifid_flush_s;
    assign stall_active = stall_active_s;
    assign stall_cnt    = stall_cnt_r;
    assign mem_timeout  = mem_timeout_r;

endmodule
